// File: rtl/spi_slave_word.sv
// SPI slave moving whole words between a serial link and valid/ready handshakes on clk.
// Optional feature macro: SPI_SLAVE_WORD_MISO_TRISTATE_EN (MISO released to Z outside a frame).
module spi_slave_word #(
  parameter int                WIDTH     = 8,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter logic [WIDTH-1:0]  IDLE_WORD = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sck,
  input  logic             ssel,
  input  logic             mosi,
  output logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             frame_active,
  output logic [7:0]       frame_count
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2:0]       sck_sync;
  logic [2:0]       ssel_sync;
  logic [1:0]       mosi_sync;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] tx_hold;
  logic             tx_full;
  logic [WIDTH-1:0] tx_shift;
  logic             load_pend;

  logic sck_rise, sck_fall, lead_edge, trail_edge;
  logic active, frame_start, sample_edge, shift_edge, word_done, load_point;
  logic [WIDTH-1:0] rx_word;

  // Synchronisers reset to the idle pin levels so no edge is seen on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= {3{CPOL}};
      ssel_sync <= 3'b111;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[1:0], sck};
      ssel_sync <= {ssel_sync[1:0], ssel};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  // Edge detection on the two oldest synchroniser stages
  assign sck_rise    = sck_sync[1] & ~sck_sync[2];
  assign sck_fall    = ~sck_sync[1] & sck_sync[2];
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign active      = ~ssel_sync[1];
  assign frame_start = active & ssel_sync[2];
  assign sample_edge = active & (CPHA ? trail_edge : lead_edge);
  assign shift_edge  = active & (CPHA ? lead_edge : trail_edge);
  assign word_done   = sample_edge & (bit_cnt == LAST);
  assign rx_word     = {rx_shift[WIDTH-2:0], mosi_sync[1]};
  assign load_point  = CPHA ? (shift_edge & (bit_cnt == '0))
                            : (frame_start | (shift_edge & load_pend));

  assign frame_active = active;
  assign tx_ready     = ~tx_full;

  // Receive path, bit counter and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      load_pend   <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      rx_overrun <= 1'b0;
      if (frame_start) frame_count <= frame_count + 8'd1;
      if (!active) begin
        bit_cnt   <= '0;
        rx_shift  <= '0;
        load_pend <= 1'b0;
      end else begin
        if (sample_edge) begin
          rx_shift <= rx_word;
          bit_cnt  <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
        end
        if (word_done)       load_pend <= 1'b1;
        else if (shift_edge) load_pend <= 1'b0;
      end
      // A consumer accepting in the completion cycle frees room for the new word
      if (word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Transmit holding entry and shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_hold     <= '0;
      tx_full     <= 1'b0;
      tx_shift    <= '0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (tx_valid && !tx_full) begin
        tx_hold <= tx_data;
        tx_full <= 1'b1;
      end
      if (!active) begin
        tx_shift <= '0;
      end else if (load_point) begin
        // An entry written this same cycle waits for the next word
        if (tx_full) begin
          tx_shift <= tx_hold;
          tx_full  <= 1'b0;
        end else begin
          tx_shift    <= IDLE_WORD;
          tx_underrun <= 1'b1;
        end
      end else if (shift_edge) begin
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      end
    end
  end

`ifdef SPI_SLAVE_WORD_MISO_TRISTATE_EN
  assign miso = active ? tx_shift[WIDTH-1] : 1'bz;
`else
  assign miso = tx_shift[WIDTH-1];
`endif

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: mode 0 / 8-bit and mode 3 / 16-bit instances driven by a bit-level SPI master.
module tb_spi_slave_word;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sck0, ssel0, mosi0, miso0;
  logic [7:0]  rx_data0, tx_data0, frame_count0;
  logic        rx_valid0, rx_ready0, rx_overrun0, tx_valid0, tx_ready0, tx_underrun0, frame_active0;

  logic        sck3, ssel3, mosi3, miso3;
  logic [15:0] rx_data3, tx_data3;
  logic [7:0]  frame_count3;
  logic        rx_valid3, rx_ready3, rx_overrun3, tx_valid3, tx_ready3, tx_underrun3, frame_active3;

  spi_slave_word dut0 (
    .clk(clk), .rst_n(rst_n), .sck(sck0), .ssel(ssel0), .mosi(mosi0), .miso(miso0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0), .rx_overrun(rx_overrun0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_underrun(tx_underrun0),
    .frame_active(frame_active0), .frame_count(frame_count0)
  );

  spi_slave_word #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .IDLE_WORD(16'h0000)) dut3 (
    .clk(clk), .rst_n(rst_n), .sck(sck3), .ssel(ssel3), .mosi(mosi3), .miso(miso3),
    .rx_data(rx_data3), .rx_valid(rx_valid3), .rx_ready(rx_ready3), .rx_overrun(rx_overrun3),
    .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3), .tx_underrun(tx_underrun3),
    .frame_active(frame_active3), .frame_count(frame_count3)
  );

  typedef struct packed {
    logic             m3;
    logic [1:0]       nw;
    logic [2:0]       have;
    logic [2:0][31:0] mo;
    logic [2:0][31:0] tx;
    logic [2:0][31:0] exp_mi;
    logic [3:0]       exp_ur;
  } vec_t;

  int total = 0;
  int bad = 0;
  int fc0 = 0;
  int fc3 = 0;
  int rd0 = 0;
  int rd3 = 0;

  // Monitors: received words, underrun and overrun pulses
  logic [31:0] got0[$];
  logic [31:0] got3[$];
  int ur0 = 0, ur3 = 0, ov0 = 0, ov3 = 0;
  always @(negedge clk) begin
    if (rst_n && rx_valid0 && rx_ready0) got0.push_back({24'h0, rx_data0});
    if (rst_n && rx_valid3 && rx_ready3) got3.push_back({16'h0, rx_data3});
    if (tx_underrun0) ur0++;
    if (tx_underrun3) ur3++;
    if (rx_overrun0) ov0++;
    if (rx_overrun3) ov3++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required orderly finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sck(input bit m3, input logic v);
    if (m3) sck3 = v; else sck0 = v;
  endtask

  task automatic set_mosi(input bit m3, input logic v);
    if (m3) mosi3 = v; else mosi0 = v;
  endtask

  task automatic set_rdy(input bit m3, input logic v);
    if (m3) rx_ready3 = v; else rx_ready0 = v;
  endtask

  task automatic set_ssel(input bit m3, input logic v);
    if (m3) begin
      if (!v) fc3++;
      ssel3 = v;
    end else begin
      if (!v) fc0++;
      ssel0 = v;
    end
  endtask

  function automatic logic get_miso(input bit m3);
    return m3 ? miso3 : miso0;
  endfunction

  function automatic logic get_rxv(input bit m3);
    return m3 ? rx_valid3 : rx_valid0;
  endfunction

  task automatic push_tx(input bit m3, input logic [31:0] d);
    int n;
    n = 0;
    while (!(m3 ? tx_ready3 : tx_ready0) && n < 50) begin
      wait_clk(1);
      n++;
    end
    chk("tx_ready_before_push", m3 ? tx_ready3 : tx_ready0, 1);
    if (m3) begin tx_data3 = d[15:0]; tx_valid3 = 1'b1; end
    else    begin tx_data0 = d[7:0];  tx_valid0 = 1'b1; end
    wait_clk(1);
    tx_valid0 = 1'b0;
    tx_valid3 = 1'b0;
  endtask

  // SPI master: SCK half period of 6 clk, MISO captured just before each sample edge
  task automatic frame(input bit m3, input int nw, input logic [2:0][31:0] mo,
                       input logic [2:0][31:0] tx, input logic [2:0] have, input bit lat,
                       input int pulse_w, input int abort_bits, output logic [2:0][31:0] mi);
    int w;
    int nb;
    bit stop;
    w = m3 ? 16 : 8;
    nb = 0;
    stop = 1'b0;
    mi = '0;
    if (have[0]) push_tx(m3, tx[0]);
    set_ssel(m3, 1'b0);
    wait_clk(6);
    for (int k = 0; k < nw; k++) begin
      for (int b = w - 1; b >= 0; b--) begin
        if (abort_bits > 0 && nb == abort_bits) stop = 1'b1;
        if (!stop) begin
          if (m3) set_sck(1'b1, 1'b0);
          set_mosi(m3, mo[k][b]);
          if (b == w - 4 && k + 1 < nw && have[k+1]) begin
            push_tx(m3, tx[k+1]);
            wait_clk(4);
          end else begin
            wait_clk(6);
          end
          mi[k][b] = get_miso(m3);
          set_sck(m3, 1'b1);
          if (b == 0 && lat) begin
            wait_clk(2);
            chk("rx_valid_before_latency", get_rxv(m3), 0);
            wait_clk(1);
            chk("rx_valid_latency", get_rxv(m3), 1);
            wait_clk(3);
          end else if (b == 0 && pulse_w == k) begin
            wait_clk(2);
            set_rdy(m3, 1'b1);
            wait_clk(1);
            set_rdy(m3, 1'b0);
            wait_clk(3);
          end else begin
            wait_clk(6);
          end
          if (!m3) set_sck(1'b0, 1'b0);
          nb++;
        end
      end
    end
    wait_clk(6);
    set_ssel(m3, 1'b1);
    set_mosi(m3, 1'b0);
    wait_clk(8);
  endtask

  // Reference: each word carries the queued TX word if one was handed over, else IDLE_WORD (0);
  // mode 0 also loads a fresh word on the SCK fall that follows the last completion.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int u;
    r = v;
    u = v.m3 ? 0 : 1;
    r.exp_mi = '0;
    for (int k = 0; k < 3; k++) begin
      if (k < int'(v.nw)) begin
        if (v.have[k]) r.exp_mi[k] = v.tx[k];
        else u++;
      end
    end
    r.exp_ur = 4'(u);
    return r;
  endfunction

  vec_t vecs [8];

  initial begin
    logic [2:0][31:0] mi;
    logic [2:0][31:0] zero3;
    logic [2:0][31:0] mo;
    logic [31:0] mask;
    int ur_b, ov_b, g_b, n;
    vec_t v;

    zero3 = '0;
    rst_n = 1'b0;
    sck0 = 1'b0; ssel0 = 1'b1; mosi0 = 1'b0; rx_ready0 = 1'b1; tx_valid0 = 1'b0; tx_data0 = '0;
    sck3 = 1'b1; ssel3 = 1'b1; mosi3 = 1'b0; rx_ready3 = 1'b1; tx_valid3 = 1'b0; tx_data3 = '0;
    wait_clk(3);
    chk("reset_miso", miso0, 0);
    chk("reset_rx_data", rx_data0, 0);
    chk("reset_rx_valid", rx_valid0, 0);
    chk("reset_rx_overrun", rx_overrun0, 0);
    chk("reset_tx_ready", tx_ready0, 1);
    chk("reset_tx_underrun", tx_underrun0, 0);
    chk("reset_frame_active", frame_active0, 0);
    chk("reset_frame_count", frame_count0, 0);
    chk("reset_tx_ready_m3", tx_ready3, 1);
    rst_n = 1'b1;
    wait_clk(4);

    // Directed vectors: mode 0 0xA5/0x3C and mode 3 two-word frame with one queued word
    vecs[0] = '0;
    vecs[0].m3 = 1'b0; vecs[0].nw = 2'd1; vecs[0].have = 3'b001;
    vecs[0].mo[0] = 32'h3C; vecs[0].tx[0] = 32'hA5;
    vecs[0].exp_mi[0] = 32'hA5; vecs[0].exp_ur = 4'd1;
    vecs[1] = '0;
    vecs[1].m3 = 1'b1; vecs[1].nw = 2'd2; vecs[1].have = 3'b001;
    vecs[1].mo[0] = 32'hBEEF; vecs[1].mo[1] = 32'h0F0F; vecs[1].tx[0] = 32'h1234;
    vecs[1].exp_mi[0] = 32'h1234; vecs[1].exp_mi[1] = 32'h0000; vecs[1].exp_ur = 4'd1;
    for (int i = 2; i < 8; i++) begin
      v = '0;
      v.m3 = i[0];
      v.nw = 2'($urandom_range(1, 3));
      v.have = 3'($urandom);
      mask = v.m3 ? 32'hFFFF : 32'hFF;
      for (int k = 0; k < 3; k++) begin
        v.mo[k] = $urandom & mask;
        v.tx[k] = $urandom & mask;
      end
      vecs[i] = model(v);
    end

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      ur_b = v.m3 ? ur3 : ur0;
      ov_b = v.m3 ? ov3 : ov0;
      frame(v.m3, int'(v.nw), v.mo, v.tx, v.have, 1'b1, -1, 0, mi);
      for (int k = 0; k < int'(v.nw); k++) begin
        chk($sformatf("v%0d_miso_word%0d", i, k), mi[k], v.exp_mi[k]);
      end
      if (v.m3) begin
        chk($sformatf("v%0d_rx_count", i), got3.size() - rd3, int'(v.nw));
        for (int k = 0; k < int'(v.nw); k++)
          if (rd3 + k < got3.size()) chk($sformatf("v%0d_rx_word%0d", i, k), got3[rd3+k], v.mo[k]);
        rd3 = got3.size();
        chk($sformatf("v%0d_frame_count", i), frame_count3, fc3 & 255);
        chk($sformatf("v%0d_tx_ready", i), tx_ready3, 1);
      end else begin
        chk($sformatf("v%0d_rx_count", i), got0.size() - rd0, int'(v.nw));
        for (int k = 0; k < int'(v.nw); k++)
          if (rd0 + k < got0.size()) chk($sformatf("v%0d_rx_word%0d", i, k), got0[rd0+k], v.mo[k]);
        rd0 = got0.size();
        chk($sformatf("v%0d_frame_count", i), frame_count0, fc0 & 255);
        chk($sformatf("v%0d_tx_ready", i), tx_ready0, 1);
      end
      chk($sformatf("v%0d_underruns", i), (v.m3 ? ur3 : ur0) - ur_b, v.exp_ur);
      chk($sformatf("v%0d_overruns", i), (v.m3 ? ov3 : ov0) - ov_b, 0);
    end

    // Overrun: two words with rx_ready held low
    rx_ready0 = 1'b0;
    ov_b = ov0;
    mo = '0; mo[0] = 32'h11; mo[1] = 32'h22;
    frame(1'b0, 2, mo, zero3, 3'b000, 1'b0, -1, 0, mi);
    chk("ovr_rx_data", rx_data0, 8'h11);
    chk("ovr_rx_valid", rx_valid0, 1);
    chk("ovr_pulses", ov0 - ov_b, 1);
    rx_ready0 = 1'b1;
    wait_clk(2);
    rx_ready0 = 1'b0;
    chk("ovr_rx_valid_cleared", rx_valid0, 0);
    rd0 = got0.size();

    // Consumer accepts exactly in the second completion cycle
    ov_b = ov0;
    g_b = got0.size();
    mo = '0; mo[0] = 32'h33; mo[1] = 32'h44;
    frame(1'b0, 2, mo, zero3, 3'b000, 1'b0, 1, 0, mi);
    chk("same_cycle_rx_data", rx_data0, 8'h44);
    chk("same_cycle_rx_valid", rx_valid0, 1);
    chk("same_cycle_overruns", ov0 - ov_b, 0);
    chk("same_cycle_handshakes", got0.size() - g_b, 1);
    if (got0.size() > g_b) chk("same_cycle_first_word", got0[g_b], 32'h33);
    rx_ready0 = 1'b1;
    wait_clk(2);
    rd0 = got0.size();

    // SSEL raised after 3 bits, then a clean frame
    mo = '0; mo[0] = 32'hFF;
    frame(1'b0, 1, mo, zero3, 3'b000, 1'b0, -1, 3, mi);
    chk("abort_no_rx", got0.size() - rd0, 0);
    chk("abort_rx_valid", rx_valid0, 0);
    mo = '0; mo[0] = 32'h5A;
    frame(1'b0, 1, mo, zero3, 3'b000, 1'b1, -1, 0, mi);
    chk("after_abort_rx_count", got0.size() - rd0, 1);
    if (got0.size() > rd0) chk("after_abort_rx_word", got0[rd0], 32'h5A);
    rd0 = got0.size();

    // frame_count wraps back to 0
    chk("fc_before_wrap", frame_count0, fc0 & 255);
    n = 256 - (fc0 & 255);
    for (int i = 0; i < n; i++) begin
      set_ssel(1'b0, 1'b0);
      wait_clk(5);
      set_ssel(1'b0, 1'b1);
      wait_clk(5);
    end
    chk("fc_wrap_zero", frame_count0, 0);
    set_ssel(1'b0, 1'b0);
    wait_clk(5);
    set_ssel(1'b0, 1'b1);
    wait_clk(5);
    chk("fc_after_wrap", frame_count0, 1);

    // Reset in the middle of a word with a pending RX word and a queued TX word
    rx_ready0 = 1'b0;
    mo = '0; mo[0] = 32'h77;
    frame(1'b0, 1, mo, zero3, 3'b000, 1'b0, -1, 0, mi);
    set_ssel(1'b0, 1'b0);
    wait_clk(6);
    push_tx(1'b0, 32'hC3);
    for (int b = 0; b < 3; b++) begin
      mosi0 = 1'b1;
      wait_clk(6);
      sck0 = 1'b1;
      wait_clk(6);
      sck0 = 1'b0;
    end
    #1 rst_n = 1'b0;
    #2;
`ifdef SPI_SLAVE_WORD_MISO_TRISTATE_EN
    chk("midreset_miso", miso0, 1'bz);
`else
    chk("midreset_miso", miso0, 0);
`endif
    chk("midreset_rx_data", rx_data0, 0);
    chk("midreset_rx_valid", rx_valid0, 0);
    chk("midreset_rx_overrun", rx_overrun0, 0);
    chk("midreset_tx_ready", tx_ready0, 1);
    chk("midreset_tx_underrun", tx_underrun0, 0);
    chk("midreset_frame_active", frame_active0, 0);
    chk("midreset_frame_count", frame_count0, 0);
    set_ssel(1'b0, 1'b1);
    sck0 = 1'b0;
    mosi0 = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    fc0 = 0;
    fc3 = 0;
    rx_ready0 = 1'b1;
    wait_clk(4);
    rd0 = got0.size();
    mo = '0; mo[0] = 32'h96;
    frame(1'b0, 1, mo, zero3, 3'b000, 1'b1, -1, 0, mi);
    chk("post_reset_rx_count", got0.size() - rd0, 1);
    if (got0.size() > rd0) chk("post_reset_rx_word", got0[rd0], 32'h96);
    chk("post_reset_frame_count", frame_count0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
